// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM state, block type and parameter defaults for the AES request arbiter
package aes_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_GAP} state_t;
  typedef logic [127:0] blk_t;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int GAP_CYCLES_DEF = 2;
endpackage

// File: rtl/aes_rr_arb2.sv
// aes_rr_arb2: two-requester round-robin grant with a last-served pointer
module aes_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] grant_o
);
  logic last_q;
  assign grant_o = &req_i ? (last_q ? 2'b01 : 2'b10) : req_i;
  // remember who was served on each accepted grant; starts at 1 so req0 wins first
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else if (take_i && |req_i) last_q <= grant_o[1];
endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one AES core between two requesters; AES_ARB_TIMEOUT_EN enables the RUN abort timer
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [127:0] resp_data,
  output logic         resp_timeout,
  output logic         aes_en,
  output logic [127:0] aes_data_in,
  output logic [127:0] aes_key_in,
  input  logic [127:0] aes_data_out,
  input  logic         aes_data_out_valid
);
  localparam int RW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
`ifdef AES_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  state_t        state_q;
  blk_t          data_q, key_q, resp_data_q;
  logic          aes_en_q, id_q, resp_valid_q, resp_id_q, resp_timeout_q;
  logic [RW-1:0] run_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [1:0]    grant;
  logic          idle, timeout;
  assign idle    = state_q == ST_IDLE;
  assign timeout = TO_EN && run_cnt_q == RW'(TIMEOUT_CYCLES - 1);
  aes_rr_arb2 u_arb (
    .clk(AES_clk),
    .rst(AES_rst),
    .req_i({req1_valid, req0_valid}),
    .take_i(idle),
    .grant_o(grant)
  );
  assign req0_ready   = ~AES_rst & idle & grant[0];
  assign req1_ready   = ~AES_rst & idle & grant[1];
  assign aes_en       = aes_en_q;
  assign aes_data_in  = data_q;
  assign aes_key_in   = key_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_data    = resp_data_q;
  assign resp_timeout = TO_EN & resp_timeout_q;
  // job sequencing: accept a grant, drive the core, hold the result, then keep the core idle for the gap
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state_q        <= ST_IDLE;
      data_q         <= '0;
      key_q          <= '0;
      id_q           <= 1'b0;
      aes_en_q       <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_data_q    <= '0;
      resp_timeout_q <= 1'b0;
      run_cnt_q      <= '0;
      gap_cnt_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (|grant) begin
          state_q  <= ST_RUN;
          aes_en_q <= 1'b1;
          id_q     <= grant[1];
          data_q   <= grant[1] ? req1_data : req0_data;
          key_q    <= grant[1] ? req1_key : req0_key;
        end
        ST_RUN: if (aes_data_out_valid || timeout) begin
          state_q        <= ST_DONE;
          aes_en_q       <= 1'b0;
          data_q         <= '0;
          key_q          <= '0;
          run_cnt_q      <= '0;
          resp_valid_q   <= 1'b1;
          resp_id_q      <= id_q;
          resp_timeout_q <= ~aes_data_out_valid;
          resp_data_q    <= aes_data_out_valid ? aes_data_out : '0;
        end else if (TO_EN) run_cnt_q <= run_cnt_q + RW'(1);
        ST_DONE: if (resp_ready) begin
          state_q      <= ST_GAP;
          resp_valid_q <= 1'b0;
        end
        ST_GAP: if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_q   <= ST_IDLE;
          gap_cnt_q <= '0;
        end else gap_cnt_q <= gap_cnt_q + GW'(1);
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: stub AES core, cycle model of the arbiter and directed scenarios
module tb_aes_req_arbiter;
  localparam int TO = 8, GAP = 2;
`ifdef AES_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic AES_clk = 1'b0, AES_rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
  logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic req0_ready, req1_ready, resp_valid, resp_id, resp_timeout, aes_en, aes_data_out_valid;
  logic [127:0] resp_data, aes_data_in, aes_key_in, aes_data_out;
  int core_lat = 3, en_cnt = 0, cyc = 0, n_chk = 0, n_fail = 0;
  bit core_mute = 1'b0, spur = 1'b0;

  aes_req_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .aes_en(aes_en), .aes_data_in(aes_data_in), .aes_key_in(aes_key_in),
    .aes_data_out(aes_data_out), .aes_data_out_valid(aes_data_out_valid)
  );

  always #5 AES_clk = ~AES_clk;

  function automatic logic [127:0] enc(input logic [127:0] d, input logic [127:0] k);
    return d ^ {k[63:0], k[127:64]};
  endfunction

  function automatic bit pick(input bit v0, input bit v1, input bit last);
    return (v0 && v1) ? !last : v1;
  endfunction

  // stub core: answers core_lat cycles after enable rises, unless muted; spur fakes a stray valid
  always @(posedge AES_clk) begin
    en_cnt <= aes_en ? en_cnt + 1 : 0;
    cyc    <= cyc + 1;
  end
  assign aes_data_out_valid = spur || (aes_en && !core_mute && en_cnt >= core_lat);
  assign aes_data_out = aes_en ? enc(aes_data_in, aes_key_in) : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  // reference model: busy with a job, holding a result, or counting down the gap
  bit m_last = 1'b1, m_run = 1'b0, m_resp = 1'b0, m_id = 1'b0, m_rid = 1'b0, m_to = 1'b0;
  int m_n = 0, m_gap = 0;
  logic [127:0] m_data = '0, m_key = '0, m_rdata = '0;
  always @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      m_last <= 1'b1; m_run <= 1'b0; m_resp <= 1'b0; m_gap <= 0; m_n <= 0;
      m_rdata <= '0; m_rid <= 1'b0; m_to <= 1'b0; m_data <= '0; m_key <= '0;
    end else if (m_run) begin
      if (!core_mute && m_n >= core_lat) begin
        m_run <= 1'b0; m_resp <= 1'b1; m_rdata <= enc(m_data, m_key); m_rid <= m_id; m_to <= 1'b0;
      end else if (TO_EN && m_n == TO - 1) begin
        m_run <= 1'b0; m_resp <= 1'b1; m_rdata <= '0; m_rid <= m_id; m_to <= 1'b1;
      end else m_n <= m_n + 1;
    end else if (m_resp) begin
      if (resp_ready) begin m_resp <= 1'b0; m_gap <= GAP; end
    end else if (m_gap > 0) m_gap <= m_gap - 1;
    else if (req0_valid || req1_valid) begin
      m_id   <= pick(req0_valid, req1_valid, m_last);
      m_last <= pick(req0_valid, req1_valid, m_last);
      m_data <= pick(req0_valid, req1_valid, m_last) ? req1_data : req0_data;
      m_key  <= pick(req0_valid, req1_valid, m_last) ? req1_key : req0_key;
      m_run  <= 1'b1;
      m_n    <= 0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge AES_clk) begin
    bit acc, g;
    acc = !AES_rst && !m_run && !m_resp && m_gap == 0 && (req0_valid || req1_valid);
    g = pick(req0_valid, req1_valid, m_last);
    chk("req0_ready", 128'(req0_ready), 128'(acc && !g));
    chk("req1_ready", 128'(req1_ready), 128'(acc && g));
    chk("aes_en", 128'(aes_en), 128'(m_run));
    chk("aes_data_in", aes_data_in, m_run ? m_data : '0);
    chk("aes_key_in", aes_key_in, m_run ? m_key : '0);
    chk("resp_valid", 128'(resp_valid), 128'(m_resp));
    if (AES_rst || m_resp) begin
      chk("resp_data", resp_data, m_resp ? m_rdata : '0);
      chk("resp_id", 128'(resp_id), 128'(m_resp && m_rid));
      chk("resp_timeout", 128'(resp_timeout), 128'(m_resp && m_to));
    end
  end

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic xfer(input bit id);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge AES_clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    chk("transfer seen", 128'(ok), 128'(1));
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n, output int en);
    n = 0;
    en = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge AES_clk);
      en += int'(aes_en);
      if (resp_valid) begin n = c; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, en, ng, nr, hs, gc, first;
    bit g_id[2], r_id[2], drop0, drop1, to_seen;
    logic [127:0] d_seen;
    logic [127:0] gold = 128'hcaa9baf4_bc1e2acc_aa2bdb40_bff6a5e8;
    // reset: outputs idle even with a request pending
    req0_valid = 1'b1;
    repeat (2) tick();
    chk("rst req0_ready", 128'(req0_ready), 128'(0));
    chk("rst aes_en", 128'(aes_en), 128'(0));
    chk("rst resp_valid", 128'(resp_valid), 128'(0));
    chk("rst aes_data_in", aes_data_in, 128'(0));
    AES_rst = 1'b0;
    req0_valid = 1'b0;
    tick();
    // single job from req0, result held for 10 cycles with req1 knocking
    core_lat = 3;
    req0_data = 128'h000000ca_00000000_00000000_00000000;
    req0_key = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    req0_valid = 1'b1;
    xfer(0);
    wait_resp(n, en);
    chk("t1 resp latency", 128'(n), 128'(5));
    chk("t1 aes_en cycles", 128'(en), 128'(4));
    chk("t1 resp_data", resp_data, gold);
    chk("t1 resp_id", 128'(resp_id), 128'(0));
    chk("t1 resp_timeout", 128'(resp_timeout), 128'(0));
    req1_data = 128'h5555;
    req1_key = 128'h6666;
    for (int c = 0; c < 10; c++) begin
      tick();
      req1_valid = 1'b1;
      @(negedge AES_clk);
      chk("hold resp_valid", 128'(resp_valid), 128'(1));
      chk("hold resp_data", resp_data, gold);
      chk("hold readies", 128'(req0_ready | req1_ready), 128'(0));
    end
    tick();
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    // reset pulsed mid-RUN discards the job
    core_lat = 6;
    req1_data = 128'h1234;
    req1_key = 128'h9abc;
    req1_valid = 1'b1;
    xfer(1);
    tick();
    tick();
    req0_valid = 1'b1;
    AES_rst = 1'b1;
    #1;
    chk("midrst aes_en", 128'(aes_en), 128'(0));
    chk("midrst aes_data_in", aes_data_in, 128'(0));
    chk("midrst aes_key_in", aes_key_in, 128'(0));
    chk("midrst req0_ready", 128'(req0_ready), 128'(0));
    chk("midrst resp_data", resp_data, 128'(0));
    tick();
    AES_rst = 1'b0;
    req0_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge AES_clk);
      n += int'(resp_valid);
    end
    chk("midrst no response", 128'(n), 128'(0));
    // both requesters together, twice: grants and responses 0,1
    core_lat = 1;
    resp_ready = 1'b1;
    req0_key = 128'h0f0f;
    req1_key = 128'hf0f0_0000_0000_0000_0000;
    for (int r = 0; r < 2; r++) begin
      tick();
      req0_data = 128'h1111 + 128'(r);
      req1_data = 128'h2222 + 128'(r);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      ng = 0; nr = 0; hs = -1; gc = -1;
      for (int c = 0; c < 80 && (ng < 2 || nr < 2); c++) begin
        @(negedge AES_clk);
        drop0 = req0_valid && req0_ready;
        drop1 = req1_valid && req1_ready;
        if ((drop0 || drop1) && ng < 2) begin
          g_id[ng] = drop1;
          ng++;
          if (ng == 2) gc = cyc;
        end
        if (resp_valid && resp_ready && nr < 2) begin
          r_id[nr] = resp_id;
          nr++;
          if (nr == 1) hs = cyc;
        end
        tick();
        if (drop0) req0_valid = 1'b0;
        if (drop1) req1_valid = 1'b0;
      end
      chk("rr grants", 128'(ng), 128'(2));
      chk("rr resps", 128'(nr), 128'(2));
      chk("rr grant0", 128'(g_id[0]), 128'(0));
      chk("rr grant1", 128'(g_id[1]), 128'(1));
      chk("rr resp_id0", 128'(r_id[0]), 128'(0));
      chk("rr resp_id1", 128'(r_id[1]), 128'(1));
      chk("gap cycles", 128'(gc - hs - 1), 128'(2));
    end
    // stray core valid while idle is ignored; then minimum latency with lat 2
    repeat (4) tick();
    spur = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge AES_clk);
      n += int'(resp_valid);
      tick();
    end
    spur = 1'b0;
    chk("spurious valid ignored", 128'(n), 128'(0));
    core_lat = 2;
    req0_data = 128'h77;
    req0_key = 128'h88;
    req0_valid = 1'b1;
    xfer(0);
    wait_resp(n, en);
    chk("lat2 resp latency", 128'(n), 128'(4));
    chk("lat2 resp_data", resp_data, 128'h88_0000_0000_0000_0077);
    // silent core
    repeat (4) tick();
    core_mute = 1'b1;
    req0_data = 128'habc;
    req0_valid = 1'b1;
    xfer(0);
    first = 0;
    to_seen = 1'b0;
    d_seen = '1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge AES_clk);
      if (resp_valid && first == 0) begin
        first = c;
        to_seen = resp_timeout;
        d_seen = resp_data;
      end
    end
`ifdef AES_ARB_TIMEOUT_EN
    chk("timeout latency", 128'(first), 128'(9));
    chk("timeout flag", 128'(to_seen), 128'(1));
    chk("timeout data", d_seen, 128'(0));
`else
    chk("silent core no resp", 128'(first), 128'(0));
    tick();
    core_mute = 1'b0;
    wait_resp(n, en);
    chk("late resp seen", 128'(n), 128'(2));
    chk("late resp_timeout", 128'(resp_timeout), 128'(0));
`endif
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of RUN cycles allowed before a job is aborted.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, the number of cycles aes_en is held low between jobs.
REQ-003 SHALL have port AES_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port AES_rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have ports reqN_valid (input, 1), reqN_ready (output, 1), reqN_data (input, 128) and reqN_key (input, 128) for N=0,1: plaintext/key request from requester N.
REQ-006 SHALL have port resp_valid, output, 1 bit: result available.
REQ-007 SHALL have port resp_ready, input, 1 bit: consumer accepts the result.
REQ-008 SHALL have port resp_id, output, 1 bit: requester index owning the result.
REQ-009 SHALL have port resp_data, output, 128 bits: ciphertext.
REQ-010 SHALL have port resp_timeout, output, 1 bit: result is an aborted job.
REQ-011 SHALL have ports aes_en (output, 1), aes_data_in (output, 128) and aes_key_in (output, 128), which drive the AES core.
REQ-012 SHALL have ports aes_data_out (input, 128) and aes_data_out_valid (input, 1), which come from the AES core.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN, DONE and GAP.
REQ-014 In IDLE, reqN_ready SHALL equal the grant for N, and a transfer SHALL occur on reqN_valid&reqN_ready; no other state asserts any reqN_ready.
REQ-015 SHALL arbitrate round-robin: when both requesters are valid, grant the one not served last; the last-served pointer resets to 1, so req0 wins first.
REQ-016 On transfer, SHALL register data, key and id, go to RUN next cycle and assert aes_en from that cycle.
REQ-017 aes_data_in and aes_key_in SHALL be stable for the whole RUN state, and SHALL be 0 outside it.
REQ-018 In RUN, SHALL hold aes_en=1 until aes_data_out_valid=1, then capture aes_data_out into resp_data and go to DONE with aes_en=0 in the next cycle.
REQ-019 In DONE, SHALL hold resp_valid=1 with stable resp_data, resp_id and resp_timeout until resp_ready=1, then go to GAP.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles with aes_en=0, then return to IDLE.
REQ-021 Minimum latency from request transfer to resp_valid SHALL be core latency + 1 cycle.
REQ-022 aes_data_out_valid asserted outside RUN SHALL be ignored.
REQ-023 A request deasserted before transfer SHALL be dropped silently; reqN_data and reqN_key are sampled only at transfer.

Reset
REQ-024 AES_rst SHALL force the IDLE state asynchronously, even mid-job, discarding any in-flight job.
REQ-025 During and after reset, SHALL drive aes_en=0, aes_data_in=0, aes_key_in=0, resp_valid=0, resp_data=0, resp_id=0, resp_timeout=0, reqN_ready=0, RUN counter=0 and GAP counter=0.

Configuration
REQ-026 With macro AES_ARB_TIMEOUT_EN defined, a RUN counter SHALL abort the job after TIMEOUT_CYCLES cycles without aes_data_out_valid, going to DONE with resp_timeout=1 and resp_data=0.
REQ-027 Without AES_ARB_TIMEOUT_EN, RUN SHALL wait indefinitely and resp_timeout SHALL be tied to 0.

Structure
REQ-028 A shared package aes_pkg SHALL hold the FSM state enum, the 128-bit block/key typedef and the defaults for TIMEOUT_CYCLES and GAP_CYCLES.
REQ-029 Round-robin grant logic SHALL be a sub-module aes_rr_arb2 (2 requesters, last-served pointer).

Verification
REQ-030 req0 data 000000ca_00000000_00000000_00000000 with key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc -> aes_en high for the whole RUN state; resp_data equals the golden ciphertext with resp_id=0 and resp_timeout=0.
REQ-031 req0 and req1 valid in the same cycle, repeated twice -> grants in the order 0,1,0,1; each resp_id matches its requester.
REQ-032 resp_ready held low for 10 cycles after resp_valid -> resp_valid and resp_data stable for 10 cycles; no reqN_ready asserted meanwhile.
REQ-033 AES_rst pulsed mid-RUN -> aes_en=0 and every output at its reset value in the same cycle; no response is produced for the aborted job.
REQ-034 With AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and a stubbed core that never asserts valid -> resp_valid after 8 RUN cycles with resp_timeout=1 and resp_data=0.
REQ-035 After each response -> aes_en low for exactly GAP_CYCLES=2 cycles before the next RUN.
